multicycle_ctrl_fsm: RTL
========================

Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle successor to the single-cycle main control decoder for the RV32I subset: R-type, addi-class I-type, lw, sw, beq/bne, jal, jalr.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath mux selects and write enables per state.
- Stalls on a memory ready handshake, with a watchdog timeout.
- Sits between the instruction register and the shared datapath (PC, IR, register file, ALU, ALUOut, MDR, unified memory).

Parameters:
- OPCODE_W, 7, opcode field width (instr_i[OPCODE_W-1:0]).
- STATE_W, 4, state register width.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready_i; 0 disables the watchdog.
- CNT_W, 4, wait-counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- instr_i  in  32  current IR contents; bits [6:0] are the opcode, bit [12] is funct3[0].
- mem_ready_i  in  1  memory has completed the pending read/write this cycle.
- zero_i  in  1  ALU zero flag.
- PCWrite  out  1  PC load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR and OldPC load enable.
- RegWrite  out  1  register-file write enable.
- MemtoReg  out  2  writeback select: 00 = ALUOut, 01 = MDR, 10 = PC.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = rs1, 10 = OldPC.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = const 4, 10 = imm.
- ALUOp  out  2  00 = add, 01 = sub/compare, 10 = R-type funct, 11 = I-type funct.
- PCSource  out  2  PC next select: 00 = ALU result, 01 = ALUOut.
- state_o  out  STATE_W  current state, for debug.
- err_o  out  1  sticky memory-timeout error.

Behaviour:
- While rst_i = 0: state = RST (0), wait counter = 0, err_o = 0. Every output is 0 in RST.
- RST always advances to FETCH on the next cycle.
- State encoding: RST 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7, EXEC_I 8, ALU_WB 9, BRANCH 10, JAL 11, JALR 12, TRAP 13, ERR 14.
- Outputs are decoded combinationally from the state. Any signal not listed for a state is 0.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 00, ALUSrcB = 01, ALUOp = 00.
  - In the cycle mem_ready_i = 1: IRWrite = 1, PCWrite = 1, PCSource = 00, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA = 10, ALUSrcB = 10, ALUOp = 00 (branch/jal target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - anything else -> see Optional Feature
- MEM_ADDR: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IorD = 1, MemRead = 1; held until mem_ready_i = 1, then MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 01 -> FETCH.
- MEM_WR: IorD = 1, MemWrite = 1; held until mem_ready_i = 1, then FETCH.
- EXEC_R: ALUSrcA = 01, ALUSrcB = 00, ALUOp = 10 -> ALU_WB.
- EXEC_I: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 11 -> ALU_WB.
- ALU_WB: RegWrite = 1, MemtoReg = 00 -> FETCH.
- BRANCH: ALUSrcA = 01, ALUSrcB = 00, ALUOp = 01, PCSource = 01.
  - PCWrite = zero_i XOR instr_i[12] (beq taken on zero, bne taken on non-zero).
  - Next state FETCH.
- JAL: RegWrite = 1, MemtoReg = 10, PCWrite = 1, PCSource = 01 -> FETCH.
- JALR: RegWrite = 1, MemtoReg = 10, ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, PCWrite = 1, PCSource = 00 -> FETCH.
- Wait counter:
  - Clears on any state change.
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready_i = 0.
  - When it equals MEM_TIMEOUT (and MEM_TIMEOUT ≠ 0) with mem_ready_i still 0: next state ERR and err_o set.
  - mem_ready_i = 1 in the same cycle as the timeout takes priority: normal advance, no error.
- ERR: all outputs 0, err_o = 1. Left only by reset.
- mem_ready_i is ignored in every state except FETCH, MEM_RD and MEM_WR.
- Reset asserted mid-instruction: state returns to RST immediately (asynchronous) and all enables drop in the same cycle.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP, where all outputs are 0 and the FSM holds until reset; state_o = 13.
- Undefined: an unknown opcode is a NOP, DECODE -> FETCH with no writes. The TRAP encoding is unused.

Decomposition:
- Shared package multicycle_ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR)
  - MemtoReg, ALUSrcA, ALUSrcB, ALUOp and PCSource encodings
- One sub-module, mem_wait_timer (CNT_W, MEM_TIMEOUT): counter plus timeout flag, cleared on state change.

Test Plan:
- Reset release, add with mem_ready_i held 1 -> states 1,2,7,9,1. RegWrite = 1 only in the ALU_WB cycle; total 4 cycles per instruction.
- lw with mem_ready_i low 3 cycles in MEM_RD -> MemRead and IorD stay 1 for 4 cycles. MEM_WB asserts RegWrite = 1, MemtoReg = 01.
- beq with zero_i = 1 -> PCWrite = 1 in BRANCH. bne (instr_i[12] = 1) with zero_i = 1 -> PCWrite = 0.
- jal then jalr -> each asserts RegWrite = 1, MemtoReg = 10, PCWrite = 1, with PCSource 01 and 00 respectively.
- mem_ready_i stuck 0 in FETCH with MEM_TIMEOUT = 15 -> ERR on cycle 16, err_o = 1 sticky. rst_i low clears it.
- Opcode 0000000: with ILLEGAL_TRAP_EN -> state 13 held. Without it -> back to FETCH, no writes.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM:
// states, opcodes and datapath select codes.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RST      = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_EXEC_I   = 4'd8,
      S_ALU_WB   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JAL      = 4'd11,
      S_JALR     = 4'd12,
      S_TRAP     = 4'd13,
      S_ERR      = 4'd14
   } state_e;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_RS1   = 2'b01;
   localparam logic [1:0] SRCA_OLDPC = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_RFN = 2'b10;
   localparam logic [1:0] ALU_IFN = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog: counts stalled cycles, flags when the
// count reaches MEM_TIMEOUT (0 disables the flag).
module mem_wait_timer #(
   parameter int CNT_W       = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic inc_i,
   output logic timeout_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign timeout_o = (MEM_TIMEOUT != 0) &&
                      (cnt_q == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I main control FSM with memory-ready watchdog.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes instead of NOP.
module multicycle_ctrl_fsm
   import multicycle_ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 7,
   parameter int STATE_W     = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [31:0]        instr_i,
   input  logic               mem_ready_i,
   input  logic               zero_i,
   output logic               PCWrite,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic [1:0]         MemtoReg,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic [1:0]         PCSource,
   output logic [STATE_W-1:0] state_o,
   output logic               err_o
);

   state_e state_q, state_d;
   logic   err_q;
   logic   wait_st, timeout;
   logic [OPCODE_W-1:0] opc;
   logic   unused_instr;

   assign opc = instr_i[OPCODE_W-1:0];
   assign unused_instr = ^{instr_i[31:13], instr_i[11:OPCODE_W]};

   assign wait_st = (state_q == S_FETCH) ||
                    (state_q == S_MEM_RD) ||
                    (state_q == S_MEM_WR);

   mem_wait_timer #(
      .CNT_W       (CNT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk_i     (clk_i),
      .rst_ni    (rst_i),
      .clr_i     (state_d != state_q),
      .inc_i     (wait_st && !mem_ready_i),
      .timeout_o (timeout)
   );

   // A ready response in the timeout cycle wins over the watchdog.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST: state_d = S_FETCH;
         S_FETCH: begin
            if (mem_ready_i)  state_d = S_DECODE;
            else if (timeout) state_d = S_ERR;
         end
         S_DECODE: begin
            case (opc)
               OPCODE_W'(OP_RTYPE):  state_d = S_EXEC_R;
               OPCODE_W'(OP_ITYPE):  state_d = S_EXEC_I;
               OPCODE_W'(OP_LOAD),
               OPCODE_W'(OP_STORE):  state_d = S_MEM_ADDR;
               OPCODE_W'(OP_BRANCH): state_d = S_BRANCH;
               OPCODE_W'(OP_JAL):    state_d = S_JAL;
               OPCODE_W'(OP_JALR):   state_d = S_JALR;
`ifdef ILLEGAL_TRAP_EN
               default:              state_d = S_TRAP;
`else
               default:              state_d = S_FETCH;
`endif
            endcase
         end
         S_MEM_ADDR:
            state_d = (opc == OPCODE_W'(OP_LOAD)) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            if (mem_ready_i)  state_d = S_MEM_WB;
            else if (timeout) state_d = S_ERR;
         end
         S_MEM_WR: begin
            if (mem_ready_i)  state_d = S_FETCH;
            else if (timeout) state_d = S_ERR;
         end
         S_MEM_WB, S_ALU_WB, S_BRANCH,
         S_JAL, S_JALR:           state_d = S_FETCH;
         S_EXEC_R, S_EXEC_I:      state_d = S_ALU_WB;
         S_TRAP, S_ERR:           state_d = state_q;
         default:                 state_d = S_ERR;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_RST;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == S_ERR) err_q <= 1'b1;
      end
   end

   always_comb begin
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemtoReg = WB_ALUOUT;
      ALUSrcA  = SRCA_PC;
      ALUSrcB  = SRCB_RS2;
      ALUOp    = ALU_ADD;
      PCSource = PC_ALU;
      case (state_q)
         S_FETCH: begin
            MemRead  = 1'b1;
            ALUSrcB  = SRCB_FOUR;
            IRWrite  = mem_ready_i;
            PCWrite  = mem_ready_i;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEM_ADDR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEM_RD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         S_MEM_WB: begin
            RegWrite = 1'b1;
            MemtoReg = WB_MDR;
         end
         S_MEM_WR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXEC_R: begin
            ALUSrcA = SRCA_RS1;
            ALUOp   = ALU_RFN;
         end
         S_EXEC_I: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALU_IFN;
         end
         S_ALU_WB: RegWrite = 1'b1;
         // funct3[0] flips beq into bne
         S_BRANCH: begin
            ALUSrcA  = SRCA_RS1;
            ALUOp    = ALU_SUB;
            PCSource = PC_ALUOUT;
            PCWrite  = zero_i ^ instr_i[12];
         end
         S_JAL: begin
            RegWrite = 1'b1;
            MemtoReg = WB_PC;
            PCWrite  = 1'b1;
            PCSource = PC_ALUOUT;
         end
         S_JALR: begin
            RegWrite = 1'b1;
            MemtoReg = WB_PC;
            ALUSrcA  = SRCA_RS1;
            ALUSrcB  = SRCB_IMM;
            PCWrite  = 1'b1;
         end
         default: ;
      endcase
   end

   assign state_o = STATE_W'(state_q);
   assign err_o   = err_q;

endmodule
